// File: rtl/mdu_gen.sv
// Multiply/divide unit with HI/LO registers, fixed-latency issue and flush/stall handshake.
// Results are computed at issue, held in temporaries, and committed to HI/LO after the latency.
module mdu_gen #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] out
);
    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam int unsigned DW      = 2 * WIDTH;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, thi_q, thi_d, tlo_q, tlo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d, tdz_q, tdz_d;

    logic             is_start_c, is_div_c, d2_zero_c, div_ovf_c;
    logic [DW-1:0]    sprod_c, uprod_c, acc_c, res_c;
    logic [WIDTH-1:0] d2_sdiv_c, d2_udiv_c, uq_c, ur_c;
    logic signed [WIDTH-1:0] sq_c, sr_c;

    // Operation decode and combinational handshake outputs
    always_comb begin
        is_start_c = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU) ||
                     (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
        is_div_c   = (op == OP_DIV) || (op == OP_DIVU);
        stall      = busy_q | is_start_c;
        out        = '0;
        if (op == OP_MFHI) out = hi_q;
        if (op == OP_MFLO) out = lo_q;
    end

    // Full-width arithmetic; divisors are forced to 1 on the zero and overflow cases
    // so the dividers never see an undefined operand pair.
    always_comb begin
        sprod_c   = {{WIDTH{d1[WIDTH-1]}}, d1} * {{WIDTH{d2[WIDTH-1]}}, d2};
        uprod_c   = {{WIDTH{1'b0}}, d1} * {{WIDTH{1'b0}}, d2};
        acc_c     = {hi_q, lo_q};
        d2_zero_c = (d2 == '0);
        div_ovf_c = (d1 == MOST_NEG) && (d2 == '1);
        d2_sdiv_c = (d2_zero_c || div_ovf_c) ? WIDTH'(1) : d2;
        d2_udiv_c = d2_zero_c ? WIDTH'(1) : d2;
        sq_c      = $signed(d1) / $signed(d2_sdiv_c);
        sr_c      = $signed(d1) % $signed(d2_sdiv_c);
        if (div_ovf_c) begin
            sq_c = $signed(MOST_NEG);
            sr_c = '0;
        end
        uq_c      = d1 / d2_udiv_c;
        ur_c      = d1 % d2_udiv_c;
        case (op)
            OP_MULT:  res_c = sprod_c;
            OP_MULTU: res_c = uprod_c;
            OP_DIV:   res_c = {sr_c, sq_c};
            OP_DIVU:  res_c = {ur_c, uq_c};
            OP_MADD:  res_c = acc_c + sprod_c;
            OP_MADDU: res_c = acc_c + uprod_c;
            OP_MSUB:  res_c = acc_c - sprod_c;
            OP_MSUBU: res_c = acc_c - uprod_c;
            default:  res_c = acc_c;
        endcase
    end

    // Next-state: countdown/commit while busy, otherwise accept starts and HI/LO moves
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        thi_d  = thi_q;
        tlo_d  = tlo_q;
        tdz_d  = tdz_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        dz_d   = 1'b0;
        if (busy_q) begin
            if (flush) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                thi_d  = '0;
                tlo_d  = '0;
                tdz_d  = 1'b0;
            end else if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                done_d = 1'b1;
                dz_d   = tdz_q;
                if (!tdz_q) begin
                    hi_d = thi_q;
                    lo_d = tlo_q;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (!flush) begin
            if (op == OP_MTHI) hi_d = d1;
            if (op == OP_MTLO) lo_d = d1;
            if (is_start_c) begin
                busy_d = 1'b1;
                cnt_d  = is_div_c ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                thi_d  = res_c[DW-1:WIDTH];
                tlo_d  = res_c[WIDTH-1:0];
                tdz_d  = is_div_c && d2_zero_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            thi_q  <= '0;
            tlo_q  <= '0;
            tdz_q  <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            thi_q  <= thi_d;
            tlo_q  <= tlo_d;
            tdz_q  <= tdz_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            dz_q   <= dz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
endmodule

// File: tb/tb_mdu_gen.sv
// Directed testbench for mdu_gen (WIDTH=32, MUL_LAT=5, DIV_LAT=10).
module tb_mdu_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic [31:0] d1, d2;
    logic        flush;
    logic        stall, busy, done, dz;
    logic [31:0] out;

    int vectors    = 0;
    int miscompares = 0;

    mdu_gen #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .op(op), .d1(d1), .d2(d2), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .dz(dz), .out(out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] o, input logic [31:0] v);
        op = o; d1 = v; step(); op = 4'd0; d1 = '0;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        op = 4'd5; #1 hi = out;
        op = 4'd6; #1 lo = out;
        op = 4'd0;
    endtask

    // Issue a start op and wait (bounded) until busy drops; returns in the done cycle.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output logic dn, output logic z);
        op = o; d1 = a; d2 = b; step();
        op = 4'd0; d1 = '0; d2 = '0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            step();
        end
        dn = done; z = dz;
    endtask

    task automatic test_reset();
        logic [31:0] hi, lo;
        reset = 1'b0; op = 4'd1; d1 = 32'd3; d2 = 32'd3; flush = 1'b0;
        step(); step();
        reset = 1'b1; op = 4'd0;
        vectors++; if ({busy, done, dz} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {busy, done, dz}); end
        read_hilo(hi, lo);
        vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_mfhi got %h want 0", hi); end
        vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_mflo got %h want 0", lo); end
    endtask

    task automatic test_mult();
        logic [31:0] hi, lo;
        op = 4'd1; d1 = 32'hFFFF_FFFE; d2 = 32'd3; #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL mult_issue_stall got %b want 1", stall); end
        step();
        op = 4'd0; d1 = '0; d2 = '0; #1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0 || stall !== 1'b1) begin
                miscompares++; $display("FAIL mult_busy_cycle%0d got busy=%b done=%b stall=%b want 1 0 1", i + 1, busy, done, stall);
            end
            step();
        end
        vectors++; if ({busy, done} !== 2'b01) begin miscompares++; $display("FAIL mult_done got busy,done=%b want 01", {busy, done}); end
        read_hilo(hi, lo);
        vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        vectors++; if (lo !== 32'hFFFF_FFFA) begin miscompares++; $display("FAIL mult_lo got %h want fffffffa", lo); end
        step();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mult_done_pulse got %b want 0", done); end
    endtask

    task automatic test_div();
        int cyc; logic dn, z; logic [31:0] hi, lo;
        run_op(4'd3, 32'd7, 32'hFFFF_FFFE, cyc, dn, z);
        vectors++; if (cyc != 10 || dn !== 1'b1 || z !== 1'b0) begin miscompares++; $display("FAIL div_timing got cyc=%0d done=%b dz=%b want 10 1 0", cyc, dn, z); end
        read_hilo(hi, lo);
        vectors++; if ({hi, lo} !== {32'h1, 32'hFFFF_FFFD}) begin miscompares++; $display("FAIL div_7_m2 got hi=%h lo=%h want 1 fffffffd", hi, lo); end
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc, dn, z);
        read_hilo(hi, lo);
        vectors++; if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin miscompares++; $display("FAIL div_ovf got hi=%h lo=%h want 0 80000000", hi, lo); end
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, cyc, dn, z);
        read_hilo(hi, lo);
        vectors++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin miscompares++; $display("FAIL div_m7_2 got hi=%h lo=%h want ffffffff fffffffd", hi, lo); end
        run_op(4'd4, 32'hFFFF_FFF9, 32'd2, cyc, dn, z);
        read_hilo(hi, lo);
        vectors++; if ({hi, lo} !== {32'h1, 32'h7FFF_FFFC}) begin miscompares++; $display("FAIL divu got hi=%h lo=%h want 1 7ffffffc", hi, lo); end
    endtask

    task automatic test_madd_msub();
        int cyc; logic dn, z; logic [31:0] hi, lo;
        write_reg(4'd8, 32'd5);
        write_reg(4'd7, 32'd0);
        run_op(4'd11, 32'd2, 32'd3, cyc, dn, z);
        vectors++; if (cyc != 5 || dn !== 1'b1) begin miscompares++; $display("FAIL msub_timing got cyc=%0d done=%b want 5 1", cyc, dn); end
        read_hilo(hi, lo);
        vectors++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin miscompares++; $display("FAIL msub got hi=%h lo=%h want ffffffff ffffffff", hi, lo); end
        write_reg(4'd8, 32'hFFFF_FFFF);
        write_reg(4'd7, 32'd0);
        run_op(4'd10, 32'd1, 32'd1, cyc, dn, z);
        read_hilo(hi, lo);
        vectors++; if ({hi, lo} !== {32'h1, 32'h0}) begin miscompares++; $display("FAIL maddu got hi=%h lo=%h want 1 0", hi, lo); end
        run_op(4'd9, 32'hFFFF_FFFF, 32'd1, cyc, dn, z);
        read_hilo(hi, lo);
        vectors++; if ({hi, lo} !== {32'h0, 32'hFFFF_FFFF}) begin miscompares++; $display("FAIL madd_neg got hi=%h lo=%h want 0 ffffffff", hi, lo); end
    endtask

    task automatic test_divzero();
        int cyc; logic dn, z; logic [31:0] hi, lo;
        write_reg(4'd7, 32'h11);
        write_reg(4'd8, 32'h22);
        run_op(4'd4, 32'h8000_0000, 32'd0, cyc, dn, z);
        vectors++; if (cyc != 10 || dn !== 1'b1 || z !== 1'b1) begin miscompares++; $display("FAIL divzero_pulse got cyc=%0d done=%b dz=%b want 10 1 1", cyc, dn, z); end
        read_hilo(hi, lo);
        vectors++; if ({hi, lo} !== {32'h11, 32'h22}) begin miscompares++; $display("FAIL divzero_hilo got hi=%h lo=%h want 11 22", hi, lo); end
        step();
        vectors++; if ({done, dz} !== 2'b00) begin miscompares++; $display("FAIL divzero_clear got done,dz=%b want 00", {done, dz}); end
    endtask

    task automatic test_flush();
        logic [31:0] hi, lo; logic seen;
        op = 4'd1; d1 = 32'd4; d2 = 32'd4; step();
        op = 4'd7; d1 = 32'h99; #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL flush_mthi_stall got %b want 1", stall); end
        step();
        op = 4'd0; d1 = '0; d2 = '0; step();
        flush = 1'b1; step(); flush = 1'b0;
        vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL flush_busy got busy,done=%b want 00", {busy, done}); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin seen = seen | done | dz; step(); end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL flush_no_done got %b want 0", seen); end
        read_hilo(hi, lo);
        vectors++; if ({hi, lo} !== {32'h11, 32'h22}) begin miscompares++; $display("FAIL flush_hilo got hi=%h lo=%h want 11 22", hi, lo); end
        op = 4'd1; d1 = 32'd4; d2 = 32'd4; flush = 1'b1; step();
        op = 4'd8; d1 = 32'h55; step();
        op = 4'd0; flush = 1'b0;
        read_hilo(hi, lo);
        vectors++; if (busy !== 1'b0 || lo !== 32'h22) begin miscompares++; $display("FAIL flush_same_cycle got busy=%b lo=%h want 0 22", busy, lo); end
    endtask

    task automatic test_back_to_back();
        int cyc; logic dn, z; logic [31:0] hi, lo;
        run_op(4'd1, 32'd2, 32'd3, cyc, dn, z);
        vectors++; if ({busy, done} !== 2'b01) begin miscompares++; $display("FAIL b2b_first got busy,done=%b want 01", {busy, done}); end
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, dn, z);
        vectors++; if (cyc != 5 || dn !== 1'b1) begin miscompares++; $display("FAIL b2b_second got cyc=%0d done=%b want 5 1", cyc, dn); end
        read_hilo(hi, lo);
        vectors++; if ({hi, lo} !== {32'hFFFF_FFFE, 32'h1}) begin miscompares++; $display("FAIL b2b_multu got hi=%h lo=%h want fffffffe 1", hi, lo); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] hi, lo; logic seen;
        op = 4'd3; d1 = 32'd100; d2 = 32'd7; step();
        op = 4'd0; d1 = '0; d2 = '0;
        for (int i = 0; i < 5; i++) step();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy6 got %b want 1", busy); end
        reset = 1'b0; step(); reset = 1'b1;
        vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL rstmid_flags got busy,done=%b want 00", {busy, done}); end
        read_hilo(hi, lo);
        vectors++; if ({hi, lo} !== 64'h0) begin miscompares++; $display("FAIL rstmid_hilo got hi=%h lo=%h want 0 0", hi, lo); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin seen = seen | done; step(); end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_done got %b want 0", seen); end
    endtask

    initial begin
        op = '0; d1 = '0; d2 = '0; flush = 1'b0; reset = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_madd_msub();
        test_divzero();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mdu_gen.md
MDU_GEN -- requirements
Module: mdu_gen

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/HI/LO width (legal: 8..64, even).
REQ-002 SHALL provide parameter MUL_LAT, default 5, busy cycles for mult/multu/madd/maddu/msub/msubu (legal ≥1).
REQ-003 SHALL provide parameter DIV_LAT, default 10, busy cycles for div/divu (legal ≥1).
REQ-004 SHALL provide the ports below, one per line.
- clk  input  1  sole clock, all state on rising edge.
- reset  input  1  synchronous, active-low: state is reset when reset==0 at a rising clk edge.
- op  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu; 13-15 treated as none.
- d1  input  WIDTH  rs operand / mthi-mtlo data.
- d2  input  WIDTH  rt operand.
- flush  input  1  cancel in-flight or same-cycle operation.
- stall  output  1  pipeline hold request.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse on HI/LO commit.
- dz  output  1  one-cycle pulse, with done, when the committed divide had d2==0.
- out  output  WIDTH  mfhi/mflo read data.

Function
REQ-005 SHALL treat op 1-4 and 9-12 as start ops; a start op SHALL be accepted only at an edge where busy==0, flush==1'b0 and reset==1.
REQ-006 SHALL, on acceptance, capture the full result into temporary HI/LO and load a down-counter with MUL_LAT or DIV_LAT.
REQ-007 SHALL hold busy=1 for exactly LAT cycles after the accepting edge; at the edge ending the LAT-th busy cycle, HI/LO SHALL take the temporary result, busy SHALL fall and done SHALL be 1 for the following cycle only.
REQ-008 SHALL drive stall = busy | (op is a start op), combinationally.
REQ-009 SHALL drive out = HI when op==mfhi, LO when op==mflo, else 0; out SHALL reflect architectural HI/LO, never temporary values.
REQ-010 SHALL write HI (mthi) or LO (mtlo) from d1 at the edge, only when busy==0 and flush==0; when busy==1 these ops SHALL be ignored.
REQ-011 mult/multu SHALL form the 2*WIDTH signed/unsigned product into {HI,LO}.
REQ-012 madd/maddu SHALL compute {HI,LO} + product, and msub/msubu SHALL compute {HI,LO} - product, signed/unsigned product as per op, modulo 2^(2*WIDTH), using HI/LO values at the accepting edge.
REQ-013 div SHALL give LO = signed quotient truncated toward zero and HI = remainder with the sign of d1; divu SHALL give the unsigned quotient and remainder.
REQ-014 div with d1 = most-negative and d2 = all-ones SHALL give LO = most-negative and HI = 0.
REQ-015 div/divu with d2==0 SHALL still run DIV_LAT busy cycles, SHALL leave HI/LO unchanged at commit, and SHALL pulse dz together with done.
REQ-016 flush==1 while busy SHALL, at that edge, clear the counter and busy, discard the temporary result, leave HI/LO unchanged, and suppress done/dz.
REQ-017 flush==1 in the same cycle as a start op, mthi or mtlo SHALL discard that op.
REQ-018 start ops presented while busy==1 SHALL be ignored; the pipeline is held by stall.
REQ-019 Back-to-back: a start op SHALL be acceptable in the cycle done==1, i.e. the first cycle with busy==0.

Reset
REQ-020 On reset==0 at an edge, HI, LO, temporaries and counter SHALL be 0, and busy, done and dz SHALL be 0, overriding any in-flight op, flush or op input.
REQ-021 out SHALL read 0 for mfhi/mflo in the first cycle after reset.

Verification (WIDTH=32, MUL_LAT=5, DIV_LAT=10)
REQ-022 mult d1=0xFFFFFFFE, d2=3 -> busy 5 cycles, done pulse, then mfhi=0xFFFFFFFF and mflo=0xFFFFFFFA; stall=1 in the issue cycle.
REQ-023 div d1=7, d2=0xFFFFFFFE -> busy 10 cycles, LO=0xFFFFFFFD, HI=1; then div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-024 mtlo 5, mthi 0, then msub d1=2, d2=3 -> HI=LO=0xFFFFFFFF; then mtlo 0xFFFFFFFF, mthi 0, maddu d1=1, d2=1 -> HI=1, LO=0.
REQ-025 divu d1=0x80000000, d2=0 with HI=0x11, LO=0x22 -> 10 busy cycles, done and dz pulse together, HI=0x11 and LO=0x22 unchanged.
REQ-026 mult 4*4 with flush=1 in the 3rd busy cycle -> busy=0 next cycle, no done, HI/LO unchanged; an mthi issued while busy is ignored.
REQ-027 reset=0 during the 6th busy cycle of a div -> next cycle busy=0, HI=LO=0, no done.
